// File: rtl/common_pkg.sv
// common_pkg: shared widths and state encoding for the SRAM controller.
//   RAM_ADDR_WIDTH : default SRAM address width (17)
//   DATA_WIDTH     : default SRAM data width (8)
//   sram_state_t   : controller FSM states IDLE / READ / WRITE / TURN
package common_pkg;

    localparam int RAM_ADDR_WIDTH = 17;
    localparam int DATA_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        TURN  = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_ctl.sv
// sram_ctl: Wishbone B4 pipelined slave driving an asynchronous SRAM.
// One access at a time; wb_stall_o is high from accept until the FSM is
// back in IDLE.
//
// Ports
//   wb_clock_i, wb_reset_n_i    : clock, asynchronous active-low reset
//   wb_addr_i, wb_data_i        : request address / write data
//   wb_we_i, wb_cycle_i,
//   wb_strobe_i                 : Wishbone controls
//   wb_data_o                   : read data (valid with wb_ack_o on reads)
//   wb_stall_o, wb_ack_o        : flow control / completion pulse
//   ram_addr_o                  : SRAM address (held for the whole access)
//   ram_data_o, ram_data_i      : SRAM data out / in
//   ram_oe_o, ram_we_o          : SRAM output enable / write enable
//   ram_data_oe                 : enable for the FPGA data-pin driver
//
// Build option
//   SRAM_TURNAROUND_EN : when defined, a write completion spends one cycle
//                        in TURN (stalled, strobes low) before IDLE.
module sram_ctl
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH = common_pkg::RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = common_pkg::DATA_WIDTH,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_n_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cycle_i,
    input  logic                  wb_strobe_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  ram_oe_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_data_oe
);

    if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
        $error("sram_ctl: READ_WAIT must be in 1..15");
    end
    if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
        $error("sram_ctl: WRITE_WAIT must be in 1..15");
    end

    sram_state_t           r_state;
    logic [3:0]            r_cnt;
    logic                  r_abort;    // wb_cycle_i dropped during this access
    logic                  r_ack;
    logic                  r_stall;
    logic                  r_oe;
    logic                  r_we;
    logic                  r_data_oe;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
            r_ack     <= 1'b0;
            r_stall   <= 1'b0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_data_oe <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wb_cycle_i && wb_strobe_i) begin
                        r_addr  <= wb_addr_i;
                        r_wdata <= wb_data_i;
                        r_stall <= 1'b1;
                        r_abort <= 1'b0;
                        if (wb_we_i) begin
                            r_state   <= WRITE;
                            r_data_oe <= 1'b1;
                            r_cnt     <= 4'(WRITE_WAIT);
                        end else begin
                            r_state <= READ;
                            r_oe    <= 1'b1;
                            r_cnt   <= 4'(READ_WAIT);
                        end
                    end
                end

                READ: begin
                    if (!wb_cycle_i) begin
                        r_abort <= 1'b1;
                    end
                    // Completion on terminal count: the counter never wraps.
                    if (r_cnt == 4'd0) begin
                        r_oe    <= 1'b0;
                        r_rdata <= ram_data_i;
                        r_ack   <= wb_cycle_i && !r_abort;
                        r_stall <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                WRITE: begin
                    if (!wb_cycle_i) begin
                        r_abort <= 1'b1;
                    end
                    // ram_we_o starts one cycle after the data driver so the
                    // bus is settled; it spans WRITE_WAIT cycles regardless of
                    // wb_cycle_i.
                    if (r_cnt == 4'd0) begin
                        r_we      <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_ack     <= wb_cycle_i && !r_abort;
`ifdef SRAM_TURNAROUND_EN
                        r_state   <= TURN;
`else
                        r_stall   <= 1'b0;
                        r_state   <= IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        r_we  <= 1'b1;
                    end
                end

                TURN: begin
                    r_stall <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb_data_o   = r_rdata;
    assign wb_stall_o  = r_stall;
    assign wb_ack_o    = r_ack;
    assign ram_oe_o    = r_oe;
    assign ram_we_o    = r_we;
    assign ram_addr_o  = r_addr;
    assign ram_data_o  = r_wdata;
    assign ram_data_oe = r_data_oe;

endmodule

// File: tb/tb_sram_ctl.sv
// tb_sram_ctl: directed, table-driven bench for sram_ctl. Three instances
// with different wait settings share the Wishbone inputs; each vector
// checks one instance cycle by cycle. Hand sequences cover pipelined
// back-to-back accepts and asynchronous reset during a read.
module tb_sram_ctl;

`ifdef SRAM_TURNAROUND_EN
    localparam int TURN_X = 1;
`else
    localparam int TURN_X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [16:0] addr_i = '0;
    logic [7:0]  din = '0;
    logic [7:0]  ram_din = '0;
    logic        we_i = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;

    logic [7:0]  dout [3];
    logic        stall [3];
    logic        ack [3];
    logic        oe [3];
    logic        rwe [3];
    logic [16:0] raddr [3];
    logic [7:0]  rdo [3];
    logic        doe [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_ctl #(.READ_WAIT(1), .WRITE_WAIT(1)) u_a (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr_i),
        .wb_data_i(din), .wb_data_o(dout[0]), .wb_we_i(we_i),
        .wb_cycle_i(cyc), .wb_strobe_i(stb), .wb_stall_o(stall[0]),
        .wb_ack_o(ack[0]), .ram_oe_o(oe[0]), .ram_we_o(rwe[0]),
        .ram_addr_o(raddr[0]), .ram_data_i(ram_din), .ram_data_o(rdo[0]),
        .ram_data_oe(doe[0]));

    sram_ctl #(.READ_WAIT(15), .WRITE_WAIT(3)) u_b (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr_i),
        .wb_data_i(din), .wb_data_o(dout[1]), .wb_we_i(we_i),
        .wb_cycle_i(cyc), .wb_strobe_i(stb), .wb_stall_o(stall[1]),
        .wb_ack_o(ack[1]), .ram_oe_o(oe[1]), .ram_we_o(rwe[1]),
        .ram_addr_o(raddr[1]), .ram_data_i(ram_din), .ram_data_o(rdo[1]),
        .ram_data_oe(doe[1]));

    sram_ctl #(.READ_WAIT(2), .WRITE_WAIT(2)) u_c (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr_i),
        .wb_data_i(din), .wb_data_o(dout[2]), .wb_we_i(we_i),
        .wb_cycle_i(cyc), .wb_strobe_i(stb), .wb_stall_o(stall[2]),
        .wb_ack_o(ack[2]), .ram_oe_o(oe[2]), .ram_we_o(rwe[2]),
        .ram_addr_o(raddr[2]), .ram_data_i(ram_din), .ram_data_o(rdo[2]),
        .ram_data_oe(doe[2]));

    // One single-access vector. Cycle k is the cycle after edge E0+k.
    //   lat        : last cycle with ram_oe_o / ram_data_oe high
    //   ack_at     : cycle with wb_ack_o high (-1: none)
    //   stall_last : last cycle with wb_stall_o high
    typedef struct {
        int          idx;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        bit          drop;
        int          lat;
        int          ack_at;
        int          stall_last;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int i;
        i = v.idx;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = v.we;
        addr_i = v.addr; din = v.wd; ram_din = v.rd;
        @(negedge clk);
        stb = 1'b0;
        if (v.drop) cyc = 1'b0;
        for (int k = 0; k < v.stall_last + 3; k++) begin
            check($sformatf("v%0d k%0d oe", vi, k), 32'(oe[i]),
                  32'(!v.we && k <= v.lat));
            check($sformatf("v%0d k%0d data_oe", vi, k), 32'(doe[i]),
                  32'(v.we && k <= v.lat));
            check($sformatf("v%0d k%0d we", vi, k), 32'(rwe[i]),
                  32'(v.we && k >= 1 && k <= v.lat));
            check($sformatf("v%0d k%0d ack", vi, k), 32'(ack[i]),
                  32'(k == v.ack_at));
            check($sformatf("v%0d k%0d stall", vi, k), 32'(stall[i]),
                  32'(k <= v.stall_last));
            check($sformatf("v%0d k%0d ram_addr", vi, k), 32'(raddr[i]),
                  32'(v.addr));
            check($sformatf("v%0d k%0d ram_data_o", vi, k), 32'(rdo[i]),
                  32'(v.wd));
            check($sformatf("v%0d k%0d oe_we_excl", vi, k),
                  32'(oe[i] & rwe[i]), 32'd0);
            check($sformatf("v%0d k%0d oe_doe_excl", vi, k),
                  32'(oe[i] & doe[i]), 32'd0);
            if (!v.we && k > v.lat)
                check($sformatf("v%0d k%0d wb_data_o", vi, k), 32'(dout[i]),
                      32'(v.rd));
            @(negedge clk);
        end
        cyc = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 17'h1ABCD, 8'h00, 8'h5A, 1'b0, 1, 2, 1};
        vecs[1] = '{0, 1'b1, 17'h00010, 8'hC3, 8'h00, 1'b0, 1, 2, 1 + TURN_X};
        vecs[2] = '{1, 1'b1, 17'h00010, 8'hC3, 8'h00, 1'b0, 3, 4, 3 + TURN_X};
        vecs[3] = '{1, 1'b0, 17'h1FFFF, 8'h11, 8'hA5, 1'b0, 15, 16, 15};
        vecs[4] = '{2, 1'b1, 17'h00123, 8'h3C, 8'h00, 1'b1, 2, -1, 2 + TURN_X};
        vecs[5] = '{2, 1'b0, 17'h00000, 8'h77, 8'hFF, 1'b0, 2, 3, 2};
        vecs[6] = '{0, 1'b0, 17'h15555, 8'h99, 8'h00, 1'b0, 1, 2, 1};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d strobes", i),
                  {28'd0, oe[i], rwe[i], doe[i], ack[i]}, 32'd0);
            check($sformatf("rst%0d stall", i), 32'(stall[i]), 32'd0);
            check($sformatf("rst%0d ram_addr", i), 32'(raddr[i]), 32'd0);
            check($sformatf("rst%0d ram_data_o", i), 32'(rdo[i]), 32'd0);
            check($sformatf("rst%0d wb_data_o", i), 32'(dout[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

        // Pipelined write then read on instance A: read accept edge.
        begin
            int acc_k;
            acc_k = -1;
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we_i = 1'b1;
            addr_i = 17'h00042; din = 8'h81;
            @(negedge clk);                 // cycle E0 of the write
            we_i = 1'b0; addr_i = 17'h00043; ram_din = 8'h6E;
            for (int k = 0; k < 10; k++) begin
                if (oe[0] && acc_k < 0) begin
                    acc_k = k;
                    stb = 1'b0;
                end
                @(negedge clk);
            end
            stb = 1'b0;
            check("b2b read accept edge", 32'(acc_k), 32'(3 + TURN_X));
            check("b2b read addr", 32'(raddr[0]), 32'h00043);
            check("b2b read data", 32'(dout[0]), 32'h6E);
            cyc = 1'b0;
            repeat (25) @(negedge clk);
        end

        // Asynchronous reset during a read on instance A.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; addr_i = 17'h0ABCD; ram_din = 8'h3F;
        @(negedge clk);
        stb = 1'b0;
        check("rstmid oe before", 32'(oe[0]), 32'd1);
        @(posedge clk);                     // E1
        #2 rst_n = 1'b0;
        #1;
        check("rstmid oe", 32'(oe[0]), 32'd0);
        check("rstmid stall", 32'(stall[0]), 32'd0);
        check("rstmid ram_addr", 32'(raddr[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rstmid no ack k%0d", k), 32'(ack[0]), 32'd0);
            check($sformatf("rstmid idle oe k%0d", k), 32'(oe[0]), 32'd0);
        end
        cyc = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
